traffic_phase_timer: RTL

//  Upstream stage of the 6x20 traffic-light decoder. Divides the system clock into a slow tick.

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/traffic_phase_timer_tick_prescaler.sv | 39 +++
 rtl/traffic_phase_timer.sv | 104 ++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and phase boundaries for the traffic phase timer.
// The pedestrian-request feature is enabled by the TRAFFIC_PED_REQ_EN macro.
package traffic_pkg;

  localparam int unsigned CODER_W = 6;
  typedef logic [CODER_W-1:0] coder_t;

  typedef enum logic [1:0] {
    ROW_GO   = 2'd0,
    ROW_WARN = 2'd1,
    COL_GO   = 2'd2,
    COL_WARN = 2'd3
  } phase_t;

  localparam coder_t ROW_WARN_START = 6'd28;
  localparam coder_t COL_GO_START   = 6'd32;
  localparam coder_t COL_WARN_START = 6'd60;
  localparam coder_t PED_ROW_JUMP   = 6'd24;
  localparam coder_t PED_COL_JUMP   = 6'd56;

  function automatic logic is_green(phase_t p);
    return (p == ROW_GO) || (p == COL_GO);
  endfunction

  function automatic logic is_warn(phase_t p);
    return (p == ROW_WARN) || (p == COL_WARN);
  endfunction

endpackage

// File: rtl/traffic_phase_timer_tick_prescaler.sv
// Clock prescaler: produces a one-cycle combinational strobe on the edge where
// the count wraps, so the caller can register it alongside its own state.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned DIV_W    = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // clear dominates run so a hold restarts a full period on release
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_timer.sv
// Cycle-position counter and phase FSM feeding the 6x20 traffic-light decoder.
// Optional pedestrian green-shortening is built when TRAFFIC_PED_REQ_EN is defined.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned DIV_W    = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       hold,
`ifdef TRAFFIC_PED_REQ_EN
  input  logic       ped_req,
`endif
  output logic [5:0] coder,
  output logic [1:0] phase,
  output logic       tick,
  output logic       phase_start
`ifdef TRAFFIC_PED_REQ_EN
  ,
  output logic       ped_pending
`endif
);

  logic   tick_w;
  coder_t coder_q, coder_d;
  phase_t phase_q, phase_d;
  logic   tick_q;
  logic   pstart_q, pstart_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .run   (enable),
    .clear (hold),
    .tick  (tick_w)
  );

`ifdef TRAFFIC_PED_REQ_EN
  logic pend_q, pend_d;
`endif

  // Next coder and phase are derived from the same wrap strobe, so tick,
  // coder, phase and phase_start all change on one edge.
  always_comb begin
    coder_d = coder_q;
    phase_d = phase_q;
    if (tick_w) begin
      coder_d = coder_q + 6'd1;
`ifdef TRAFFIC_PED_REQ_EN
      if (pend_q && phase_q == ROW_GO && coder_q < PED_ROW_JUMP) coder_d = PED_ROW_JUMP;
      if (pend_q && phase_q == COL_GO && coder_q < PED_COL_JUMP) coder_d = PED_COL_JUMP;
`endif
      case (phase_q)
        ROW_GO:   if (coder_d == ROW_WARN_START) phase_d = ROW_WARN;
        ROW_WARN: if (coder_d == COL_GO_START)   phase_d = COL_GO;
        COL_GO:   if (coder_d == COL_WARN_START) phase_d = COL_WARN;
        COL_WARN: if (coder_d == '0)             phase_d = ROW_GO;
        default:  phase_d = ROW_GO;
      endcase
    end
    pstart_d = (phase_d != phase_q);
  end

`ifdef TRAFFIC_PED_REQ_EN
  // Entering a warn phase clears the request even if one arrives on that edge.
  always_comb begin
    pend_d = pend_q;
    if (ped_req && is_green(phase_q)) pend_d = 1'b1;
    if (phase_d != phase_q && is_warn(phase_d)) pend_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end

  assign ped_pending = pend_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      coder_q  <= '0;
      phase_q  <= ROW_GO;
      tick_q   <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      coder_q  <= coder_d;
      phase_q  <= phase_d;
      tick_q   <= tick_w;
      pstart_q <= pstart_d;
    end
  end

  assign coder       = coder_q;
  assign phase       = phase_q;
  assign tick        = tick_q;
  assign phase_start = pstart_q;

endmodule
